// File: rtl/ro_buffer_pkg.sv
// Shared configuration, entry flag layout and tag arithmetic for the reorder buffer.
package ro_buffer_pkg;

  localparam int unsigned DEF_ROB_ID_WIDTH = 4;
  localparam int unsigned DEF_REG_ID_WIDTH = 5;
  localparam int unsigned DEF_XLEN         = 32;
  localparam int unsigned DEF_CAP          = (2 ** DEF_ROB_ID_WIDTH) - 1;

  typedef struct packed {
    logic busy;
    logic ready;
    logic mispredict;
  } entry_flags_t;

  // Tag 0 is reserved for "no dependency", so the pointer wraps from cap to 1.
  function automatic logic [7:0] next_tag(input logic [7:0] tag, input logic [7:0] cap);
    return (tag >= cap) ? 8'd1 : tag + 8'd1;
  endfunction

endpackage

// File: rtl/ro_buffer_entry_array.sv
// Reorder buffer entry storage: allocation, CDB writeback, retirement and two operand lookups.
module ro_buffer_entry_array
  import ro_buffer_pkg::*;
#(
  parameter int unsigned ROB_ID_WIDTH = DEF_ROB_ID_WIDTH,
  parameter int unsigned REG_ID_WIDTH = DEF_REG_ID_WIDTH,
  parameter int unsigned XLEN         = DEF_XLEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    clear,
  input  logic                    alloc_en,
  input  logic [ROB_ID_WIDTH-1:0] alloc_id,
  input  logic [REG_ID_WIDTH-1:0] alloc_rd,
  input  logic                    wb_valid,
  input  logic [ROB_ID_WIDTH-1:0] wb_id,
  input  logic [XLEN-1:0]         wb_value,
  input  logic                    wb_mispredict,
  input  logic [XLEN-1:0]         wb_target,
  input  logic                    free_en,
  input  logic [ROB_ID_WIDTH-1:0] head_id,
  output logic                    head_busy,
  output logic                    head_ready,
  output logic                    head_mispredict,
  output logic [REG_ID_WIDTH-1:0] head_rd,
  output logic [XLEN-1:0]         head_value,
  output logic [XLEN-1:0]         head_target,
  input  logic [ROB_ID_WIDTH-1:0] query_j_id,
  output logic                    query_j_ready,
  output logic [XLEN-1:0]         query_j_value,
  input  logic [ROB_ID_WIDTH-1:0] query_k_id,
  output logic                    query_k_ready,
  output logic [XLEN-1:0]         query_k_value
);

  localparam int unsigned DEPTH = 2 ** ROB_ID_WIDTH;

  entry_flags_t            flags    [DEPTH];
  logic [REG_ID_WIDTH-1:0] rd_q     [DEPTH];
  logic [XLEN-1:0]         value_q  [DEPTH];
  logic [XLEN-1:0]         target_q [DEPTH];

  logic wb_en;
  assign wb_en = wb_valid && (wb_id != '0) && flags[wb_id].busy;

  // Later assignments win: retirement overrides a stray writeback, allocation targets a free slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) flags[i] <= '0;
    end else if (rdy) begin
      if (clear) begin
        for (int unsigned i = 0; i < DEPTH; i++) flags[i] <= '0;
      end else begin
        if (wb_en) begin
          flags[wb_id].ready      <= 1'b1;
          flags[wb_id].mispredict <= wb_mispredict;
        end
        if (free_en) flags[head_id] <= '0;
        if (alloc_en) flags[alloc_id] <= '{busy: 1'b1, ready: 1'b0, mispredict: 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && rdy && !clear) begin
      if (alloc_en) rd_q[alloc_id] <= alloc_rd;
      if (wb_en) begin
        value_q[wb_id]  <= wb_value;
        target_q[wb_id] <= wb_target;
      end
    end
  end

  assign head_busy       = flags[head_id].busy;
  assign head_ready      = flags[head_id].ready;
  assign head_mispredict = flags[head_id].mispredict;
  assign head_rd         = rd_q[head_id];
  assign head_value      = value_q[head_id];
  assign head_target     = target_q[head_id];

  always_comb begin
    query_j_ready = 1'b0;
    query_j_value = '0;
    if (query_j_id != '0) begin
      if (wb_valid && wb_id == query_j_id) begin
        query_j_ready = 1'b1;
        query_j_value = wb_value;
      end else if (flags[query_j_id].ready) begin
        query_j_ready = 1'b1;
        query_j_value = value_q[query_j_id];
      end
    end
  end

  always_comb begin
    query_k_ready = 1'b0;
    query_k_value = '0;
    if (query_k_id != '0) begin
      if (wb_valid && wb_id == query_k_id) begin
        query_k_ready = 1'b1;
        query_k_value = wb_value;
      end else if (flags[query_k_id].ready) begin
        query_k_ready = 1'b1;
        query_k_value = value_q[query_k_id];
      end
    end
  end

endmodule

// File: rtl/ro_buffer.sv
// Reorder buffer top: tag allocation, in-order commit to the register file and mispredict flush.
module ro_buffer
  import ro_buffer_pkg::*;
#(
  parameter int unsigned ROB_ID_WIDTH = DEF_ROB_ID_WIDTH,
  parameter int unsigned REG_ID_WIDTH = DEF_REG_ID_WIDTH,
  parameter int unsigned XLEN         = DEF_XLEN
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    rdy,
  input  logic                    issue_valid,
  input  logic [REG_ID_WIDTH-1:0] issue_rd,
  output logic [ROB_ID_WIDTH-1:0] dest_to_issuer,
  output logic                    full_to_issuer,
  input  logic                    cdb_valid,
  input  logic [ROB_ID_WIDTH-1:0] cdb_dest,
  input  logic [XLEN-1:0]         cdb_value,
  input  logic                    cdb_mispredict,
  input  logic [XLEN-1:0]         cdb_target,
  input  logic [ROB_ID_WIDTH-1:0] query_j_id,
  output logic                    query_j_ready,
  output logic [XLEN-1:0]         query_j_value,
  input  logic [ROB_ID_WIDTH-1:0] query_k_id,
  output logic                    query_k_ready,
  output logic [XLEN-1:0]         query_k_value,
  output logic [ROB_ID_WIDTH-1:0] dest_to_reg_file,
  output logic [REG_ID_WIDTH-1:0] rd_to_reg_file,
  output logic [XLEN-1:0]         value_to_reg_file,
  output logic                    reset_to_rob_bus,
  output logic [XLEN-1:0]         pc_to_fetcher
);

  localparam int unsigned CAP = (2 ** ROB_ID_WIDTH) - 1;
  localparam logic [ROB_ID_WIDTH-1:0] FIRST_TAG = ROB_ID_WIDTH'(1);

  function automatic logic [ROB_ID_WIDTH-1:0] inc_tag(input logic [ROB_ID_WIDTH-1:0] t);
    return ROB_ID_WIDTH'(next_tag(8'(t), 8'(CAP)));
  endfunction

  logic [ROB_ID_WIDTH-1:0] head, tail, count;
  logic                    flush_pending;

  logic                    head_busy, head_ready, head_mispredict;
  logic [REG_ID_WIDTH-1:0] head_rd;
  logic [XLEN-1:0]         head_value, head_target;
  logic                    commit, alloc;

  assign full_to_issuer = (count == ROB_ID_WIDTH'(CAP));
  assign dest_to_issuer = tail;
  assign commit = head_busy && head_ready && !flush_pending;
  assign alloc  = issue_valid && !full_to_issuer && !flush_pending;

  ro_buffer_entry_array #(
    .ROB_ID_WIDTH(ROB_ID_WIDTH),
    .REG_ID_WIDTH(REG_ID_WIDTH),
    .XLEN        (XLEN)
  ) u_entries (
    .clk            (clk),
    .rst_n          (rst_n),
    .rdy            (rdy),
    .clear          (flush_pending),
    .alloc_en       (alloc),
    .alloc_id       (tail),
    .alloc_rd       (issue_rd),
    .wb_valid       (cdb_valid),
    .wb_id          (cdb_dest),
    .wb_value       (cdb_value),
    .wb_mispredict  (cdb_mispredict),
    .wb_target      (cdb_target),
    .free_en        (commit),
    .head_id        (head),
    .head_busy      (head_busy),
    .head_ready     (head_ready),
    .head_mispredict(head_mispredict),
    .head_rd        (head_rd),
    .head_value     (head_value),
    .head_target    (head_target),
    .query_j_id     (query_j_id),
    .query_j_ready  (query_j_ready),
    .query_j_value  (query_j_value),
    .query_k_id     (query_k_id),
    .query_k_ready  (query_k_ready),
    .query_k_value  (query_k_value)
  );

  // flush_pending mirrors reset_to_rob_bus but survives a rdy-low stall so the clear is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head              <= FIRST_TAG;
      tail              <= FIRST_TAG;
      count             <= '0;
      flush_pending     <= 1'b0;
      dest_to_reg_file  <= '0;
      rd_to_reg_file    <= '0;
      value_to_reg_file <= '0;
      reset_to_rob_bus  <= 1'b0;
      pc_to_fetcher     <= '0;
    end else if (!rdy) begin
      dest_to_reg_file <= '0;
      reset_to_rob_bus <= 1'b0;
    end else if (flush_pending) begin
      head             <= FIRST_TAG;
      tail             <= FIRST_TAG;
      count            <= '0;
      flush_pending    <= 1'b0;
      dest_to_reg_file <= '0;
      reset_to_rob_bus <= 1'b0;
    end else begin
      dest_to_reg_file <= (commit && head_rd != '0) ? head : '0;
      reset_to_rob_bus <= commit && head_mispredict;
      flush_pending    <= commit && head_mispredict;
      if (commit) begin
        rd_to_reg_file    <= head_rd;
        value_to_reg_file <= head_value;
        if (head_mispredict) pc_to_fetcher <= head_target;
        head <= inc_tag(head);
      end
      if (alloc) tail <= inc_tag(tail);
      case ({alloc, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_buffer.sv
// Directed self-checking bench for ro_buffer with hand-computed expectations.
module tb_ro_buffer;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [3:0]  dest_to_issuer;
  logic        full_to_issuer;
  logic        cdb_valid;
  logic [3:0]  cdb_dest;
  logic [31:0] cdb_value;
  logic        cdb_mispredict;
  logic [31:0] cdb_target;
  logic [3:0]  query_j_id, query_k_id;
  logic        query_j_ready, query_k_ready;
  logic [31:0] query_j_value, query_k_value;
  logic [3:0]  dest_to_reg_file;
  logic [4:0]  rd_to_reg_file;
  logic [31:0] value_to_reg_file;
  logic        reset_to_rob_bus;
  logic [31:0] pc_to_fetcher;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ro_buffer #(.ROB_ID_WIDTH(4), .REG_ID_WIDTH(5), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .dest_to_issuer(dest_to_issuer), .full_to_issuer(full_to_issuer),
    .cdb_valid(cdb_valid), .cdb_dest(cdb_dest), .cdb_value(cdb_value),
    .cdb_mispredict(cdb_mispredict), .cdb_target(cdb_target),
    .query_j_id(query_j_id), .query_j_ready(query_j_ready), .query_j_value(query_j_value),
    .query_k_id(query_k_id), .query_k_ready(query_k_ready), .query_k_value(query_k_value),
    .dest_to_reg_file(dest_to_reg_file), .rd_to_reg_file(rd_to_reg_file),
    .value_to_reg_file(value_to_reg_file), .reset_to_rob_bus(reset_to_rob_bus),
    .pc_to_fetcher(pc_to_fetcher)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [31:0] val, input logic mp, input logic [31:0] tgt);
    cdb_valid = 1'b1; cdb_dest = tag; cdb_value = val; cdb_mispredict = mp; cdb_target = tgt;
  endtask

  task automatic cdb_idle();
    cdb_valid = 1'b0; cdb_dest = '0; cdb_value = '0; cdb_mispredict = 1'b0; cdb_target = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; rdy = 1'b1; issue_valid = 1'b0; issue_rd = '0;
    query_j_id = '0; query_k_id = '0;
    cdb_idle();
    step(); step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_dest_to_issuer", 32'(dest_to_issuer), 32'd1);
    check("rst_full", 32'(full_to_issuer), 32'd0);
    check("rst_dest_rf", 32'(dest_to_reg_file), 32'd0);
    check("rst_flush", 32'(reset_to_rob_bus), 32'd0);

    // In-order commit despite out-of-order writeback
    issue_valid = 1'b1; issue_rd = 5'd5; #1;
    check("inord_tag1", 32'(dest_to_issuer), 32'd1);
    step();
    issue_rd = 5'd6; #1;
    check("inord_tag2", 32'(dest_to_issuer), 32'd2);
    step();
    issue_valid = 1'b0;
    cdb(4'd2, 32'h22, 1'b0, 32'h0);
    step();
    cdb(4'd1, 32'h11, 1'b0, 32'h0);
    check("inord_no_early_commit", 32'(dest_to_reg_file), 32'd0);
    step();
    cdb_idle();
    check("inord_latency", 32'(dest_to_reg_file), 32'd0);
    step();
    check("inord_c1_dest", 32'(dest_to_reg_file), 32'd1);
    check("inord_c1_rd", 32'(rd_to_reg_file), 32'd5);
    check("inord_c1_val", value_to_reg_file, 32'h11);
    step();
    check("inord_c2_dest", 32'(dest_to_reg_file), 32'd2);
    check("inord_c2_rd", 32'(rd_to_reg_file), 32'd6);
    check("inord_c2_val", value_to_reg_file, 32'h22);
    step();
    check("inord_idle", 32'(dest_to_reg_file), 32'd0);

    // Fill to capacity, ignored issue while full, wrap to tag 1
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd7;
    for (int i = 1; i <= 15; i++) begin
      check("fill_tag", 32'(dest_to_issuer), 32'(i));
      step();
    end
    check("full_set", 32'(full_to_issuer), 32'd1);
    check("full_tail_wrap", 32'(dest_to_issuer), 32'd1);
    step();
    check("full_ignored_full", 32'(full_to_issuer), 32'd1);
    check("full_ignored_tail", 32'(dest_to_issuer), 32'd1);
    issue_valid = 1'b0;
    cdb(4'd1, 32'h55, 1'b0, 32'h0);
    step();
    cdb_idle();
    step();
    check("full_retire_dest", 32'(dest_to_reg_file), 32'd1);
    check("full_retire_val", value_to_reg_file, 32'h55);
    check("full_cleared", 32'(full_to_issuer), 32'd0);
    check("full_next_tag", 32'(dest_to_issuer), 32'd1);
    issue_valid = 1'b1;
    step();
    issue_valid = 1'b0;
    check("full_refill", 32'(full_to_issuer), 32'd1);
    check("full_refill_tail", 32'(dest_to_issuer), 32'd2);

    // Mispredict flush
    do_reset();
    issue_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      issue_rd = 5'(i);
      step();
    end
    issue_valid = 1'b0;
    cdb(4'd1, 32'hAA, 1'b1, 32'h1000);
    step();
    cdb(4'd2, 32'hBB, 1'b0, 32'h0);
    step();
    check("flush_dest", 32'(dest_to_reg_file), 32'd1);
    check("flush_val", value_to_reg_file, 32'hAA);
    check("flush_pulse", 32'(reset_to_rob_bus), 32'd1);
    check("flush_pc", pc_to_fetcher, 32'h1000);
    issue_valid = 1'b1; issue_rd = 5'd4;
    cdb(4'd3, 32'hCC, 1'b0, 32'h0);
    step();
    issue_valid = 1'b0;
    cdb_idle();
    query_j_id = 4'd2; query_k_id = 4'd3; #1;
    check("flush_pulse_end", 32'(reset_to_rob_bus), 32'd0);
    check("flush_no_commit", 32'(dest_to_reg_file), 32'd0);
    check("flush_tail", 32'(dest_to_issuer), 32'd1);
    check("flush_not_full", 32'(full_to_issuer), 32'd0);
    check("flush_q_tag2", 32'(query_j_ready), 32'd0);
    check("flush_q_tag3", 32'(query_k_ready), 32'd0);
    step();
    check("flush_tag2_never_1", 32'(dest_to_reg_file), 32'd0);
    step();
    check("flush_tag2_never_2", 32'(dest_to_reg_file), 32'd0);

    // CDB bypass on the query ports
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd1;
    step(); step(); step();
    issue_valid = 1'b0;
    cdb(4'd3, 32'hABCD, 1'b0, 32'h0);
    query_j_id = 4'd3; query_k_id = 4'd0; #1;
    check("byp_j_ready", 32'(query_j_ready), 32'd1);
    check("byp_j_value", query_j_value, 32'hABCD);
    check("byp_k0_ready", 32'(query_k_ready), 32'd0);
    check("byp_k0_value", query_k_value, 32'd0);
    step();
    cdb_idle();
    query_k_id = 4'd2; #1;
    check("stored_j_ready", 32'(query_j_ready), 32'd1);
    check("stored_j_value", query_j_value, 32'hABCD);
    check("pending_k_ready", 32'(query_k_ready), 32'd0);

    // rd=0 retires silently; rdy low stalls commit
    do_reset();
    issue_valid = 1'b1; issue_rd = 5'd0;
    step();
    issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    cdb(4'd1, 32'h77, 1'b0, 32'h0);
    step();
    cdb(4'd2, 32'h99, 1'b0, 32'h0);
    step();
    cdb_idle();
    check("rd0_no_write", 32'(dest_to_reg_file), 32'd0);
    rdy = 1'b0;
    step();
    check("stall_1", 32'(dest_to_reg_file), 32'd0);
    step();
    check("stall_2", 32'(dest_to_reg_file), 32'd0);
    rdy = 1'b1;
    step();
    check("resume_dest", 32'(dest_to_reg_file), 32'd2);
    check("resume_rd", 32'(rd_to_reg_file), 32'd9);
    check("resume_val", value_to_reg_file, 32'h99);
    step();
    check("resume_idle", 32'(dest_to_reg_file), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
